rule90_ca: RTL and testbench
============================

// Module: rule90_ca
// PURPOSE
//  - 1-D cellular automaton register array implementing Wolfram Rule 90.
//  - Every clock, each cell becomes the XOR of its two neighbours (the cell's own value is ignored).
//  - Parallel-loadable 512-cell state, visible on q.
//  - Standalone pattern generator for fractal/pseudo-random bit fields (Sierpinski triangle from a single set bit).
// PARAMETERS
//  - WIDTH  512  number of cells; q and data are WIDTH bits; must be >= 2.
// PORTS
//  - clk    in   1      rising-edge clock; all state changes on its rising edge
//  - reset  in   1      synchronous, active-high reset
//  - load   in   1      when 1, q takes data at the next edge
//  - data   in   WIDTH  parallel load value
//  - q      out  WIDTH  current cell states, driven directly from the state register
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. No other clocks or async paths.
//  - Priority at each rising edge: reset > load > step.
//  - reset=1: q <= 0. A reset mid-run discards the pattern, and q stays 0 while stepping (0 is a fixed point).
//  - load=1 (reset=0): q <= data, with no step that cycle.
//  - load held high: q re-loads data every cycle; stepping resumes on the first edge with load=0.
//  - step (reset=0, load=0): for all i, q[i] <= q[i-1] ^ q[i+1], all cells computed from pre-edge q.
//  - Boundary (default build): q[-1] = 0 and q[WIDTH] = 0, so
//    - q[0] <= q[1]
//    - q[WIDTH-1] <= q[WIDTH-2]
//  - Latency: a load or step is visible on q one edge later. No combinational path from inputs to q.
//  - After power-up and before the first reset or load, q is undefined.
//  - No overflow or wrap behaviour beyond the boundary rule. Pure XOR, no arithmetic.
// CONFIGURATION
//  - Macro RULE90_WRAP_EN.
//  - Undefined (default): zero boundary as above.
//  - Defined: toroidal ring, so
//    - q[0] <= q[WIDTH-1] ^ q[1]
//    - q[WIDTH-1] <= q[WIDTH-2] ^ q[0]
//  - Reset and load behaviour are identical in both builds.
// TESTING
//  - Single seed: reset=1 for 1 cycle, load data=1 (bit 0 only), then load=0.
//    q sequence = 0x1, 0x2, 0x5, 0x8, 0x14.
//  - Centre seed: load data bit 256 only, then step.
//    - Step 1: bits 255 and 257 set.
//    - Step 2: bits 254 and 258 set.
//    - Q[256] = 0 on odd steps.
//  - Edge seed: load data bit 511 only, then step.
//    - Default build: bit 510 only, then bits 509 and 511.
//    - RULE90_WRAP_EN build, bit-0 seed: bits 1 and 511 after one step.
//  - Priority: assert reset=1 and load=1 together with data=all-ones -> q = 0. Then reset=0, load=1 -> q = all-ones.
//    - One step from all-ones (default build): q = 1 at bits 0 and 511 only, all other bits 0.
//  - Load held high: data incremented every cycle while load=1 -> q tracks data with 1-cycle lag.
//    - Release load: stepping starts from the last loaded value.
//  - Random seed: data=random, run 1000 steps, compare every cycle against a bit-accurate golden model -> 0 mismatches.

Source files
------------

// File: rtl/rule90_ca.sv
// ============================================================================
//  Module      : rule90_ca
//  Description : Wolfram Rule 90 cellular automaton with a parallel-loadable
//                WIDTH-cell state. Define RULE90_WRAP_EN for a toroidal ring,
//                otherwise cells beyond both ends read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rule90_ca #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] left_nbr;
    logic [WIDTH-1:0] right_nbr;
    logic [WIDTH-1:0] next_q;

    // left_nbr[i] holds q[i-1], right_nbr[i] holds q[i+1]
    always_comb begin
`ifdef RULE90_WRAP_EN
        left_nbr  = {q[WIDTH-2:0], q[WIDTH-1]};
        right_nbr = {q[0], q[WIDTH-1:1]};
`else
        left_nbr  = {q[WIDTH-2:0], 1'b0};
        right_nbr = {1'b0, q[WIDTH-1:1]};
`endif
        next_q = left_nbr ^ right_nbr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else begin
            q <= next_q;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rule90_ca.sv
// ============================================================================
//  Module      : tb_rule90_ca
//  Description : Self-checking bench for rule90_ca against a per-cell model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rule90_ca;

    localparam int WIDTH = 512;
`ifdef RULE90_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] model;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rule90_ca #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .data  (data),
        .q     (q)
    );

    // Each cell becomes XOR of the cells on either side; off-array cells are 0
    // unless the array is a ring.
    function automatic logic [WIDTH-1:0] rule90_next(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] n;
        logic             l;
        logic             r;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == 0)             l = WRAP ? s[WIDTH-1] : 1'b0;
            else                    l = s[i-1];
            if (i == WIDTH-1)       r = WRAP ? s[0] : 1'b0;
            else                    r = s[i+1];
            n[i] = l ^ r;
        end
        return n;
    endfunction

    function automatic logic [WIDTH-1:0] onehot(input int k);
        logic [WIDTH-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] rand_vec();
        logic [WIDTH-1:0] v;
        for (int w = 0; w < WIDTH/32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs for one edge and advance the model alongside the DUT.
    task automatic cycle(input logic r, input logic l, input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] nxt;
        reset = r;
        load  = l;
        data  = d;
        if (r)      nxt = '0;
        else if (l) nxt = d;
        else        nxt = rule90_next(model);
        @(posedge clk);
        #1;
        model = nxt;
    endtask

    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] last_d;
    logic [WIDTH-1:0] exp_seq [5];

    initial begin
        reset = 1'b1;
        load  = 1'b0;
        data  = '0;
        model = '0;
        ones  = '1;

        // Reset
        cycle(1'b1, 1'b0, '0);
        check("reset", q, '0);

        // Single seed at bit 0
        exp_seq[0] = WIDTH'(64'h1);
        exp_seq[1] = WIDTH'(64'h2);
        exp_seq[2] = WIDTH'(64'h5);
        exp_seq[3] = WIDTH'(64'h8);
        exp_seq[4] = WIDTH'(64'h14);
        cycle(1'b0, 1'b1, WIDTH'(64'h1));
        check("seed0_load", q, exp_seq[0]);
        for (int s = 1; s < 5; s++) begin
            cycle(1'b0, 1'b0, '0);
            if (!WRAP) check($sformatf("seed0_step%0d", s), q, exp_seq[s]);
            check($sformatf("seed0_model%0d", s), q, model);
        end

        // Centre seed
        cycle(1'b0, 1'b1, onehot(256));
        check("centre_load", q, onehot(256));
        cycle(1'b0, 1'b0, '0);
        check("centre_step1", q, onehot(255) | onehot(257));
        cycle(1'b0, 1'b0, '0);
        check("centre_step2", q, onehot(254) | onehot(258));
        for (int s = 3; s <= 12; s++) begin
            cycle(1'b0, 1'b0, '0);
            check($sformatf("centre_model%0d", s), q, model);
            if (s % 2 == 1) check($sformatf("centre_mid%0d", s), WIDTH'(q[256]), '0);
        end

        // Edge seeds
        cycle(1'b0, 1'b1, onehot(WIDTH-1));
        cycle(1'b0, 1'b0, '0);
        if (WRAP) check("edge_step1", q, onehot(WIDTH-2) | onehot(0));
        else      check("edge_step1", q, onehot(WIDTH-2));
        cycle(1'b0, 1'b0, '0);
        if (!WRAP) check("edge_step2", q, onehot(WIDTH-3) | onehot(WIDTH-1));
        check("edge_model2", q, model);
        cycle(1'b0, 1'b1, onehot(0));
        cycle(1'b0, 1'b0, '0);
        if (WRAP) check("bit0_step1", q, onehot(1) | onehot(WIDTH-1));
        else      check("bit0_step1", q, onehot(1));

        // Priority: reset beats load, then load, then one step from all-ones
        cycle(1'b1, 1'b1, ones);
        check("prio_reset", q, '0);
        cycle(1'b0, 1'b1, ones);
        check("prio_load", q, ones);
        cycle(1'b0, 1'b0, '0);
        if (WRAP) check("ones_step", q, '0);
        else      check("ones_step", q, onehot(0) | onehot(WIDTH-1));

        // Load held high with incrementing data
        d = rand_vec();
        last_d = d;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, d);
            check($sformatf("held_load%0d", k), q, d);
            last_d = d;
            d = d + 1'b1;
        end
        cycle(1'b0, 1'b0, '0);
        check("held_release", q, rule90_next(last_d));

        // Reset mid-run keeps zero while stepping
        cycle(1'b1, 1'b0, '0);
        check("midreset", q, '0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, '0);
            check($sformatf("zero_fixed%0d", k), q, '0);
        end

        // Random seed, long run
        cycle(1'b0, 1'b1, rand_vec());
        check("rand_load", q, model);
        for (int s = 1; s <= 1000; s++) begin
            cycle(1'b0, 1'b0, '0);
            check($sformatf("rand_step%0d", s), q, model);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
